tick_pwm_timer: RTL
===================

Name: tick_pwm_timer

Overview:
Programmable period/duty PWM timer clocked by the tick enable that the clock divider produces. It sits directly downstream of the divider and consumes its enable output as tick_in. Each tick_in rising edge (or each high cycle, in level mode) advances a period counter. The block drives a PWM waveform and a one-cycle wrap pulse per period. Period and duty are double-buffered so they change only on a period boundary.

Parameters:
CNT_W, 8, width of counter, period and duty.

Ports:
clk  input  1  system clock, same domain as the divider.
rstn  input  1  synchronous reset, active-low.
tick_in  input  1  divider enable output (level waveform).
tick_mode  input  1  0 = edge mode: a tick on each tick_in rising edge; 1 = level mode: a tick on every clk with tick_in=1 (divide-by-1 bypass).
run  input  1  1 = count, 0 = stop and clear.
period  input  CNT_W  period value P; period length is P+1 ticks.
duty  input  CNT_W  duty value D; PWM is high while cnt < D.
cfg_load  input  1  one-cycle strobe that captures period and duty.
pwm_out  output  1  PWM waveform, registered.
wrap_pulse  output  1  one-clk pulse when the counter wraps P -> 0.
cnt  output  CNT_W  current count.
cfg_pend  output  1  a captured config is waiting for a boundary.

Behaviour:
- Reset (rstn=0 at posedge clk), all synchronous:
  - state=IDLE; cnt=0; pwm_out=0; wrap_pulse=0; cfg_pend=0; tick_q=0.
  - period_sh = all ones; duty_sh = 0; pending registers = 0.
  - Reset mid-period aborts the period immediately; no wrap_pulse is issued.
- Tick generation:
  - tick_q is tin_in registered every cycle.
  - Edge mode: tick = tick_in & ~tick_q.
  - Level mode: tick = tick_in.
  - Consequence: a constant-high tick_in yields exactly one tick in edge mode and one tick every clk in level mode.
  - Changing tick_mode takes effect on the next cycle's tick evaluation.
- State IDLE:
  - cnt=0; pwm_out=0; ticks are ignored.
  - cfg_load loads period_sh/duty_sh directly on the next edge; cfg_pend stays 0.
  - run=1 -> RUN on the next edge with cnt=0. pwm_out becomes (0 < duty_sh) in that same cycle.
- State RUN, on a tick:
  - cnt==period_sh: cnt<=0; wrap_pulse<=1 for exactly one clk; pending config (if cfg_pend) is copied to the shadows and cfg_pend<=0.
  - Otherwise: cnt<=cnt+1.
  - No tick: cnt holds and wrap_pulse<=0.
- State RUN, other events:
  - run=0 -> IDLE on the next edge: cnt<=0, pwm_out<=0, wrap_pulse<=0, no wrap issued. Pending config is applied on entering IDLE.
  - cfg_load: captures period/duty into the pending registers and sets cfg_pend=1. A later cfg_load before the boundary overwrites the pending values.
  - cfg_load in the same cycle as a wrapping tick: the new values go straight to the shadows at that wrap; cfg_pend stays 0.
- pwm_out:
  - Registered, aligned with cnt: in every cycle pwm_out == (state==RUN && cnt < duty_sh), using the shadow value in force that cycle.
  - D=0: always low. D > P: always high. D = P: low only in the cnt==P tick.
- P=0: every tick wraps. wrap_pulse follows each tick; in level mode with tick_in constant high, wrap_pulse is high continuously.
- Arithmetic: cnt never exceeds period_sh. If period_sh is reduced below the current cnt, that can only happen at a boundary, where cnt is already 0. No overflow path exists.
- Latency: tick_in rise -> cnt/pwm_out/wrap_pulse update 1 clk later in level mode, 1 clk later in edge mode (edge is detected combinationally against tick_q).

Test Plan:
- Reset, then tick_mode=1, tick_in=1 constant, cfg_load with P=4, D=2 in IDLE, run=1 -> cnt sequence 0,1,2,3,4,0…; pwm_out 1,1,0,0,0 repeating; wrap_pulse exactly on the clk where cnt returns to 0, every 5 clks.
- tick_mode=0, tick_in toggling high 5 / low 5 clks (divider factor 10), P=3, D=1 -> cnt advances once per 10 clks; wrap every 40 clks; pwm_out high for 10 of every 40 clks.
- RUN with P=4, D=2; cfg_load P=2, D=3 at cnt=1 -> cfg_pend=1 until the wrap; the old period completes (5 ticks); then cnt 0,1,2 with pwm_out constantly high; cfg_pend=0 after the wrap.
- cfg_load coincident with the wrapping tick (P=4 -> P=1) -> the next period is 2 ticks; cfg_pend never asserts.
- Boundaries: D=0 -> pwm_out always 0; D=8, P=4 -> always 1; P=0 in level mode -> wrap_pulse continuous high, cnt stays 0.
- run=0 at cnt=3 -> next clk cnt=0, pwm_out=0, no wrap_pulse. rstn=0 mid-period -> all outputs zero the next clk, period_sh=0xFF, duty_sh=0.

Source files
------------

// File: rtl/tick_pwm_timer_if.sv
`default_nettype none
// ============================================================================
//  Module      : tick_pwm_timer_if
//  Description : Control/status bundle of the tick-driven PWM timer.
//                The master side drives ticks and configuration; the
//                slave side (the timer) returns the waveform and status.
//  Revision    : 1.0 - initial release
// ============================================================================
interface tick_pwm_timer_if #(
    parameter int CNT_W = 8
);
    logic             tick_in;
    logic             tick_mode;
    logic             run;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] duty;
    logic             cfg_load;
    logic             pwm_out;
    logic             wrap_pulse;
    logic [CNT_W-1:0] cnt;
    logic             cfg_pend;

    modport master (
        output tick_in, tick_mode, run, period, duty, cfg_load,
        input  pwm_out, wrap_pulse, cnt, cfg_pend
    );

    modport slave (
        input  tick_in, tick_mode, run, period, duty, cfg_load,
        output pwm_out, wrap_pulse, cnt, cfg_pend
    );
endinterface
`default_nettype wire

// File: rtl/tick_pwm_timer.sv
`default_nettype none
// ============================================================================
//  Module      : tick_pwm_timer
//  Description : Period/duty PWM timer advanced by the divider tick enable.
//                Period and duty are double-buffered and only change on a
//                period boundary (or when the timer is idle/stopped).
//  Revision    : 1.0 - initial release
// ============================================================================
module tick_pwm_timer #(
    parameter int CNT_W = 8
) (
    input  wire logic         clk,
    input  wire logic         rstn,
    tick_pwm_timer_if.slave   bus
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] c_one = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_pwm;
    logic             r_wrap;
    logic             r_cfg_pend;
    logic             r_tick_q;
    logic [CNT_W-1:0] r_period_sh;
    logic [CNT_W-1:0] r_duty_sh;
    logic [CNT_W-1:0] r_period_pend;
    logic [CNT_W-1:0] r_duty_pend;

    state_t           w_state_nx;
    logic [CNT_W-1:0] w_cnt_nx;
    logic             w_pwm_nx;
    logic             w_wrap_nx;
    logic             w_cfg_pend_nx;
    logic [CNT_W-1:0] w_period_sh_nx;
    logic [CNT_W-1:0] w_duty_sh_nx;
    logic [CNT_W-1:0] w_period_pend_nx;
    logic [CNT_W-1:0] w_duty_pend_nx;
    logic             w_tick;
    logic             w_at_end;

    // Tick qualifier: rising edge of tick_in, or every high cycle in level mode.
    always_comb begin
        w_tick   = bus.tick_mode ? bus.tick_in : (bus.tick_in & ~r_tick_q);
        w_at_end = (r_cnt == r_period_sh);
    end

    // Next-state, counter and double-buffer update logic.
    always_comb begin
        w_state_nx       = r_state;
        w_cnt_nx         = r_cnt;
        w_wrap_nx        = 1'b0;
        w_cfg_pend_nx    = r_cfg_pend;
        w_period_sh_nx   = r_period_sh;
        w_duty_sh_nx     = r_duty_sh;
        w_period_pend_nx = r_period_pend;
        w_duty_pend_nx   = r_duty_pend;

        case (r_state)
            ST_IDLE: begin
                // Nothing is running, so configuration lands directly.
                w_cnt_nx      = '0;
                w_cfg_pend_nx = 1'b0;
                if (bus.cfg_load) begin
                    w_period_sh_nx = bus.period;
                    w_duty_sh_nx   = bus.duty;
                end
                if (bus.run) begin
                    w_state_nx = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!bus.run) begin
                    // Stopping is a boundary: flush any waiting config,
                    // but a fresh load in this cycle is the newest value.
                    w_state_nx    = ST_IDLE;
                    w_cnt_nx      = '0;
                    w_cfg_pend_nx = 1'b0;
                    if (r_cfg_pend) begin
                        w_period_sh_nx = r_period_pend;
                        w_duty_sh_nx   = r_duty_pend;
                    end
                    if (bus.cfg_load) begin
                        w_period_sh_nx = bus.period;
                        w_duty_sh_nx   = bus.duty;
                    end
                end else if (w_tick && w_at_end) begin
                    // Period boundary: a coincident load bypasses the pending stage.
                    w_cnt_nx      = '0;
                    w_wrap_nx     = 1'b1;
                    w_cfg_pend_nx = 1'b0;
                    if (bus.cfg_load) begin
                        w_period_sh_nx = bus.period;
                        w_duty_sh_nx   = bus.duty;
                    end else if (r_cfg_pend) begin
                        w_period_sh_nx = r_period_pend;
                        w_duty_sh_nx   = r_duty_pend;
                    end
                end else begin
                    if (w_tick) begin
                        w_cnt_nx = r_cnt + c_one;
                    end
                    if (bus.cfg_load) begin
                        w_period_pend_nx = bus.period;
                        w_duty_pend_nx   = bus.duty;
                        w_cfg_pend_nx    = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nx = ST_IDLE;
                w_cnt_nx   = '0;
            end
        endcase

        // PWM is computed from next-cycle values so it stays aligned with cnt.
        w_pwm_nx = (w_state_nx == ST_RUN) && (w_cnt_nx < w_duty_sh_nx);
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state       <= ST_IDLE;
            r_cnt         <= '0;
            r_pwm         <= 1'b0;
            r_wrap        <= 1'b0;
            r_cfg_pend    <= 1'b0;
            r_tick_q      <= 1'b0;
            r_period_sh   <= '1;
            r_duty_sh     <= '0;
            r_period_pend <= '0;
            r_duty_pend   <= '0;
        end else begin
            r_state       <= w_state_nx;
            r_cnt         <= w_cnt_nx;
            r_pwm         <= w_pwm_nx;
            r_wrap        <= w_wrap_nx;
            r_cfg_pend    <= w_cfg_pend_nx;
            r_tick_q      <= bus.tick_in;
            r_period_sh   <= w_period_sh_nx;
            r_duty_sh     <= w_duty_sh_nx;
            r_period_pend <= w_period_pend_nx;
            r_duty_pend   <= w_duty_pend_nx;
        end
    end

    // Output drive.
    always_comb begin
        bus.cnt        = r_cnt;
        bus.pwm_out    = r_pwm;
        bus.wrap_pulse = r_wrap;
        bus.cfg_pend   = r_cfg_pend;
    end

endmodule
`default_nettype wire
